mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the core's single 64-bit memory port between the instruction-fetch requester and the load/store (data) requester. Request path is zero-latency combinational, so fetch keeps its same-cycle address redirect. An in-order owner FIFO routes each memory response back to the requester that issued it. A starvation guard bounds how long data-side priority can block fetch.

Parameters:
Xlen, 64, address/data width; memory data is 64 bits
MaxOutstandingLog2, 2, log2 of the maximum number of in-flight requests (4)
StarveLimit, 4, consecutive blocked fetch cycles before fetch wins priority; range 1..15

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
if_valid_i  in  1  fetch request valid
if_ready_o  out  1  fetch request accepted this cycle
if_addr_i  in  Xlen  fetch address
if_rdata_o  out  Xlen  fetch response data (= mem_rdata_i)
if_rvalid_o  out  1  fetch response valid
dm_valid_i  in  1  data request valid
dm_ready_o  out  1  data request accepted this cycle
dm_addr_i  in  Xlen  data address
dm_we_i  in  1  1 = write
dm_wmask_i  in  8  byte write strobes
dm_wdata_i  in  Xlen  write data
dm_rdata_o  out  Xlen  data response data (= mem_rdata_i)
dm_rvalid_o  out  1  data response valid; for writes this is the ack
mem_valid_o  out  1  request to memory
mem_ready_i  in  1  memory accepts request
mem_addr_o  out  Xlen  muxed address
mem_we_o  out  1  muxed write enable; 0 when fetch is granted
mem_wmask_o  out  8  muxed strobes; 0 when fetch is granted
mem_wdata_o  out  Xlen  muxed write data
mem_rdata_i  in  Xlen  memory response data
mem_rvalid_i  in  1  memory response valid; exactly one per accepted request, in order
outstanding_o  out  MaxOutstandingLog2+1  in-flight request count
err_o  out  1  sticky protocol error

Behaviour:
- Reset: while rst_ni is low, clear the owner FIFO, starvation counter and err_o. All outputs then read: if_ready_o=0, dm_ready_o=0, if_rvalid_o=0, dm_rvalid_o=0, mem_valid_o=0, outstanding_o=0, err_o=0. Reset mid-operation discards in-flight ownership; memory is reset by the same signal.
- full = (outstanding == 2**MaxOutstandingLog2).
- mem_valid_o = (if_valid_i | dm_valid_i) & !full.
- Grant is combinational, re-evaluated every cycle, with no lock:
  - grant_if = if_valid_i & (!dm_valid_i | starve_hit), where starve_hit = (starve_cnt >= StarveLimit).
  - Otherwise grant_dm = dm_valid_i.
- Request mux: mem_addr/we/wmask/wdata_o follow the granted requester. When neither requester is valid they are don't-care but must be driven from the fetch side (no X).
- Ready: if_ready_o = grant_if & mem_ready_i & !full; dm_ready_o = grant_dm & mem_ready_i & !full. At most one is high in any cycle.
- Owner FIFO (1-bit entries, 0 = fetch, 1 = data):
  - Push the granted owner on a mem handshake (mem_valid_o & mem_ready_i).
  - Pop on mem_rvalid_i when non-empty.
  - Push and pop in the same cycle are both allowed, including when the FIFO holds one entry.
  - Full blocks issue even if a pop occurs in the same cycle; there is no bypass.
  - Pointers wrap modulo 2**MaxOutstandingLog2.
  - outstanding_o = count register, updated by +1 on push, -1 on pop, unchanged on push+pop.
- Response routing: if_rvalid_o = mem_rvalid_i & !empty & head==0; dm_rvalid_o = mem_rvalid_i & !empty & head==1. Same-cycle, no registering. rdata outputs are a plain copy of mem_rdata_i.
- Error: mem_rvalid_i with an empty FIFO is dropped (no rvalid to either requester) and sets err_o until reset.
- Starvation counter (4-bit, saturating):
  - Increments each cycle if_valid_i & !if_ready_o & dm_ready_o.
  - Clears on a fetch handshake.
  - Holds otherwise, including when fetch drops valid on a redirect.
- Responses to fetch requests issued before a control hazard are still delivered; discarding them is the fetch unit's job.

Test Plan:
- Fetch only, mem_ready_i=1, 1-cycle memory latency, addrs 0x0,0x4,0x8 → if_ready_o high each cycle; if_rvalid_o follows one cycle later with matching data; outstanding_o stays 1; dm_rvalid_o never asserts.
- Both valid every cycle, StarveLimit=4 → dm wins 4 consecutive cycles, fetch wins the 5th, counter clears, and the pattern repeats; responses route in issue order D,D,D,D,I.
- Memory stalls responses, 5 requests offered → 4 accepted; outstanding_o=4 and both readies stay 0. First rvalid then pops the FIFO; the 5th request is accepted the following cycle, not the same cycle.
- Data write (we=1, wmask=0xF0, wdata=0xDEADBEEF00000000) then fetch → mem_we_o=1 and wmask=0xF0 on cycle 1; mem_we_o=0 and wmask=0 on cycle 2; ack arrives on dm_rvalid_o, fetch data on if_rvalid_o.
- Spurious mem_rvalid_i with outstanding_o=0 → no rvalid on either port; err_o=1 and stays high; rst_ni pulsed low asynchronously mid-cycle → err_o, outstanding_o and all rvalids drop to 0 immediately.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with an
// in-order owner FIFO that steers each response back to its requester.
module mem_port_arbiter #(
  parameter int Xlen               = 64,
  parameter int MaxOutstandingLog2 = 2,
  parameter int StarveLimit        = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        if_valid_i,
  output logic                        if_ready_o,
  input  logic [Xlen-1:0]             if_addr_i,
  output logic [Xlen-1:0]             if_rdata_o,
  output logic                        if_rvalid_o,
  input  logic                        dm_valid_i,
  output logic                        dm_ready_o,
  input  logic [Xlen-1:0]             dm_addr_i,
  input  logic                        dm_we_i,
  input  logic [7:0]                  dm_wmask_i,
  input  logic [Xlen-1:0]             dm_wdata_i,
  output logic [Xlen-1:0]             dm_rdata_o,
  output logic                        dm_rvalid_o,
  output logic                        mem_valid_o,
  input  logic                        mem_ready_i,
  output logic [Xlen-1:0]             mem_addr_o,
  output logic                        mem_we_o,
  output logic [7:0]                  mem_wmask_o,
  output logic [Xlen-1:0]             mem_wdata_o,
  input  logic [Xlen-1:0]             mem_rdata_i,
  input  logic                        mem_rvalid_i,
  output logic [MaxOutstandingLog2:0] outstanding_o,
  output logic                        err_o
);

  localparam int PtrW  = MaxOutstandingLog2;
  localparam int Depth = 1 << PtrW;
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  logic [Depth-1:0] owner_q;
  ptr_t             wr_ptr_q;
  ptr_t             rd_ptr_q;
  cnt_t             count_q;
  logic [3:0]       starve_q;
  logic             err_q;

  logic full;
  logic empty;
  logic starve_hit;
  logic grant_if;
  logic grant_dm;
  logic push;
  logic pop;
  logic head;

  assign full       = (count_q == FullCnt);
  assign empty      = (count_q == '0);
  assign starve_hit = (starve_q >= 4'(StarveLimit));
  assign grant_if   = if_valid_i & (~dm_valid_i | starve_hit);
  assign grant_dm   = dm_valid_i & ~grant_if;

  // Request side is gated by reset so nothing leaks out while rst_ni is low.
  assign mem_valid_o = rst_ni & (if_valid_i | dm_valid_i) & ~full;
  assign if_ready_o  = rst_ni & grant_if & mem_ready_i & ~full;
  assign dm_ready_o  = rst_ni & grant_dm & mem_ready_i & ~full;

  assign mem_addr_o  = grant_dm ? dm_addr_i  : if_addr_i;
  assign mem_we_o    = grant_dm & dm_we_i;
  assign mem_wmask_o = grant_dm ? dm_wmask_i : 8'h00;
  assign mem_wdata_o = dm_wdata_i;

  assign push = mem_valid_o & mem_ready_i;
  assign pop  = mem_rvalid_i & ~empty;
  assign head = owner_q[rd_ptr_q];

  assign if_rvalid_o   = pop & ~head;
  assign dm_rvalid_o   = pop & head;
  assign if_rdata_o    = mem_rdata_i;
  assign dm_rdata_o    = mem_rdata_i;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

  // Owner entries are only read while valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (push) owner_q[wr_ptr_q] <= grant_dm;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
      if (if_ready_o)
        starve_q <= 4'h0;
      else if (if_valid_i & dm_ready_o & (starve_q != 4'hF))
        starve_q <= starve_q + 4'h1;
      if (mem_rvalid_i & empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_port_arbiter;
  localparam int Xlen = 64;
  localparam int MOL  = 2;
  localparam int SL   = 4;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            if_valid_i, if_ready_o, if_rvalid_o;
  logic [Xlen-1:0] if_addr_i, if_rdata_o;
  logic            dm_valid_i, dm_ready_o, dm_we_i, dm_rvalid_o;
  logic [Xlen-1:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic [7:0]      dm_wmask_i, mem_wmask_o;
  logic            mem_valid_o, mem_ready_i, mem_we_o, mem_rvalid_i;
  logic [Xlen-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [MOL:0]    outstanding_o;
  logic            err_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.Xlen(Xlen), .MaxOutstandingLog2(MOL), .StarveLimit(SL)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
    .dm_valid_i(dm_valid_i), .dm_ready_o(dm_ready_o), .dm_addr_i(dm_addr_i),
    .dm_we_i(dm_we_i), .dm_wmask_i(dm_wmask_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_rvalid_o(dm_rvalid_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] resp_of(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0]};
  endfunction

  // Reference model: owners of in-flight requests in issue order.
  bit m_owner[$];
  int m_starve = 0;
  bit m_err    = 1'b0;

  always @(negedge clk) begin : model
    bit full, hit, gi, gd, e_mv, e_ir, e_dr, e_irv, e_drv;
    if (!rst_ni) begin
      chk("rst_if_ready", if_ready_o, 0);
      chk("rst_dm_ready", dm_ready_o, 0);
      chk("rst_mem_valid", mem_valid_o, 0);
      chk("rst_if_rvalid", if_rvalid_o, 0);
      chk("rst_dm_rvalid", dm_rvalid_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_err", err_o, 0);
      m_owner.delete();
      m_starve = 0;
      m_err    = 1'b0;
    end else begin
      full  = (m_owner.size() == (1 << MOL));
      hit   = (m_starve >= SL);
      gi    = if_valid_i && (!dm_valid_i || hit);
      gd    = dm_valid_i && !gi;
      e_mv  = (if_valid_i || dm_valid_i) && !full;
      e_ir  = gi && mem_ready_i && !full;
      e_dr  = gd && mem_ready_i && !full;
      e_irv = mem_rvalid_i && (m_owner.size() > 0) && (m_owner[0] == 1'b0);
      e_drv = mem_rvalid_i && (m_owner.size() > 0) && (m_owner[0] == 1'b1);
      chk("mem_valid", mem_valid_o, e_mv);
      chk("if_ready", if_ready_o, e_ir);
      chk("dm_ready", dm_ready_o, e_dr);
      chk("if_rvalid", if_rvalid_o, e_irv);
      chk("dm_rvalid", dm_rvalid_o, e_drv);
      chk("outstanding", outstanding_o, m_owner.size());
      chk("err", err_o, m_err);
      chk("if_rdata", if_rdata_o, mem_rdata_i);
      chk("dm_rdata", dm_rdata_o, mem_rdata_i);
      if (e_mv) begin
        chk("mem_addr", mem_addr_o, gd ? dm_addr_i : if_addr_i);
        chk("mem_we", mem_we_o, gd && dm_we_i);
        chk("mem_wmask", mem_wmask_o, gd ? dm_wmask_i : 8'h00);
        if (gd) chk("mem_wdata", mem_wdata_o, dm_wdata_i);
      end
      if (mem_rvalid_i) begin
        if (m_owner.size() > 0) void'(m_owner.pop_front());
        else m_err = 1'b1;
      end
      if (e_mv && mem_ready_i) m_owner.push_back(gd);
      if (e_ir) m_starve = 0;
      else if (if_valid_i && e_dr && m_starve < 15) m_starve++;
    end
  end

  // Bench memory: answers each accepted request one cycle later while enabled.
  logic [63:0] pend_q[$];
  bit          resp_en;

  task automatic step();
    logic        hs;
    logic [63:0] a;
    @(negedge clk);
    hs = mem_valid_o && mem_ready_i;
    a  = mem_addr_o;
    if (hs) pend_q.push_back(resp_of(a));
    @(posedge clk);
    #1;
    if (resp_en && pend_q.size() > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend_q.pop_front();
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 64'h0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] pat;
    rst_ni = 1'b0;
    if_valid_i = 1'b1; if_addr_i = '0;
    dm_valid_i = 1'b0; dm_addr_i = '0; dm_we_i = 1'b0; dm_wmask_i = '0; dm_wdata_i = '0;
    mem_ready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    resp_en = 1'b1;
    #12;
    chk("reset_if_ready", if_ready_o, 0);
    chk("reset_mem_valid", mem_valid_o, 0);
    chk("reset_outstanding", outstanding_o, 0);
    chk("reset_err", err_o, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    if_valid_i = 1'b0;

    // Fetch-only stream with single-cycle memory.
    for (int i = 0; i < 3; i++) begin
      if_valid_i = 1'b1;
      if_addr_i  = 64'(4 * i);
      #1;
      chk("t1_if_ready", if_ready_o, 1);
      if (i > 0) begin
        chk("t1_outstanding", outstanding_o, 1);
        chk("t1_if_rvalid", if_rvalid_o, 1);
        chk("t1_if_rdata", if_rdata_o, resp_of(64'(4 * (i - 1))));
      end
      step();
    end
    if_valid_i = 1'b0;
    #1;
    chk("t1_last_if_rvalid", if_rvalid_o, 1);
    chk("t1_dm_rvalid", dm_rvalid_o, 0);
    step(); step();

    // Both requesters valid every cycle: starvation guard rotates priority.
    pat = '0;
    if_valid_i = 1'b1;
    dm_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if_addr_i = 64'h40 + 64'(4 * i);
      dm_addr_i = 64'h1000 + 64'(8 * i);
      #1;
      pat = {pat[8:0], dm_ready_o};
      step();
    end
    chk("t2_grant_pattern", {54'h0, pat}, 64'b1111011110);
    if_valid_i = 1'b0;
    dm_valid_i = 1'b0;
    step(); step(); step();

    // Stalled memory: four requests fill the owner FIFO.
    resp_en    = 1'b0;
    dm_valid_i = 1'b1;
    dm_addr_i  = 64'h2000;
    repeat (4) step();
    #1;
    chk("t3_outstanding_full", outstanding_o, 4);
    chk("t3_dm_ready_full", dm_ready_o, 0);
    chk("t3_if_ready_full", if_ready_o, 0);
    resp_en = 1'b1;
    step();
    #1;
    chk("t3_pop_dm_rvalid", dm_rvalid_o, 1);
    chk("t3_no_bypass", dm_ready_o, 0);
    chk("t3_outstanding_pop", outstanding_o, 4);
    step();
    #1;
    chk("t3_fifth_accepted", dm_ready_o, 1);
    dm_valid_i = 1'b0;
    repeat (6) step();

    // Data write followed by a fetch.
    dm_valid_i = 1'b1; dm_we_i = 1'b1; dm_wmask_i = 8'hF0;
    dm_wdata_i = 64'hDEADBEEF00000000; dm_addr_i = 64'h3000;
    #1;
    chk("t4_we_write", mem_we_o, 1);
    chk("t4_wmask_write", mem_wmask_o, 8'hF0);
    chk("t4_wdata_write", mem_wdata_o, 64'hDEADBEEF00000000);
    step();
    dm_valid_i = 1'b0; dm_we_i = 1'b0; dm_wmask_i = 8'h00;
    if_valid_i = 1'b1; if_addr_i = 64'h100;
    #1;
    chk("t4_we_fetch", mem_we_o, 0);
    chk("t4_wmask_fetch", mem_wmask_o, 8'h00);
    chk("t4_write_ack", dm_rvalid_o, 1);
    step();
    if_valid_i = 1'b0;
    #1;
    chk("t4_fetch_resp", if_rvalid_o, 1);
    step(); step();

    // Spurious response, then asynchronous reset with a response in flight.
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'hBAD;
    #1;
    chk("t5_spur_if_rvalid", if_rvalid_o, 0);
    chk("t5_spur_dm_rvalid", dm_rvalid_o, 0);
    step();
    #1;
    chk("t5_err_set", err_o, 1);
    step();
    #1;
    chk("t5_err_sticky", err_o, 1);
    if_valid_i = 1'b1; if_addr_i = 64'h200;
    step();
    if_valid_i = 1'b0;
    #1;
    chk("t5_pre_rst_if_rvalid", if_rvalid_o, 1);
    chk("t5_pre_rst_outstanding", outstanding_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_err", err_o, 0);
    chk("t5_rst_outstanding", outstanding_o, 0);
    chk("t5_rst_if_rvalid", if_rvalid_o, 0);
    chk("t5_rst_dm_rvalid", dm_rvalid_o, 0);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    pend_q.delete();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    if_valid_i = 1'b1; if_addr_i = 64'h300;
    #1;
    chk("t5_after_rst_if_ready", if_ready_o, 1);
    step();
    if_valid_i = 1'b0;
    #1;
    chk("t5_after_rst_if_rvalid", if_rvalid_o, 1);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
